pipe_hazard_ctrl: RTL

- Produces all hold/flush/bubble controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register of the 5-stage RV64 core.
- Detects load-use hazards, flushes wrong-path instructions on taken branches/jumps, and freezes the pipe while data memory is busy.
- Sits beside the decode stage and is fed by the ID and EX register outputs.

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/ldu_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg : state encodings, register constants and control bundles
//                 shared by the pipeline hazard controller.  Rev 1.0
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int FLUSH_CNT_W = 3;
  localparam int PERF_CNT_W  = 16;

  typedef struct packed {
    logic pc_en;
    logic if_id_hazard;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_en;
    logic mem_wb_en;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_hazard: 1'b0, if_id_flush: 1'b0,
                                 id_ex_bubble: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  localparam ctrl_t CTRL_STALL = '{pc_en: 1'b0, if_id_hazard: 1'b1, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{pc_en: 1'b1, if_id_hazard: 1'b0, if_id_flush: 1'b1,
                                   id_ex_bubble: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_hazard: 1'b1, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0};

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if : ID/EX/MEM hazard inputs and pipeline-register controls;
//                       PIPE_HAZARD_PERF_EN adds the perf counter outputs.  Rev 1.0
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if
`ifdef PIPE_HAZARD_PERF_EN
  #(parameter int CNT_W = pipe_ctrl_pkg::PERF_CNT_W)
`endif
  ();

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_en;
  logic       if_id_hazard;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       timeout_err;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_lu_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;
  logic [CNT_W-1:0] perf_memwait_cnt;
`endif

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect, mem_req, mem_ready,
    output pc_en, if_id_hazard, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
           timeout_err
`ifdef PIPE_HAZARD_PERF_EN
    , output perf_lu_cnt, perf_flush_cnt, perf_memwait_cnt
`endif
  );

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect, mem_req, mem_ready,
    input  pc_en, if_id_hazard, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
           timeout_err
`ifdef PIPE_HAZARD_PERF_EN
    , input perf_lu_cnt, perf_flush_cnt, perf_memwait_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/ldu_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ldu_detect : load-use comparator between the load in EX and the ID sources.
// Rev 1.0
// ---------------------------------------------------------------------------
module ldu_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  output logic       lu_o
);

  // x0 is hard-wired, so a load targeting it never creates a dependency
  assign lu_o = ex_memread_i && (ex_rd_i != REG_X0) &&
                ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : hold/flush/bubble/freeze control for the 5-stage RV64 pipe;
//                    define PIPE_HAZARD_PERF_EN for saturating perf counters.  Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
`ifdef PIPE_HAZARD_PERF_EN
  ,
  parameter int CNT_W        = PERF_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              arst_n,
  pipe_hazard_ctrl_if.slave hz_if
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0]      WAIT_LIMIT   = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   pend_q, pend_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   tmo_q, tmo_d;

  logic  lu;
  logic  mw;
  ctrl_t ctrl;
  ctrl_t ctrl_out;

  ldu_detect u_ldu (
    .id_rs1_i     (hz_if.id_rs1),
    .id_rs2_i     (hz_if.id_rs2),
    .ex_rd_i      (hz_if.ex_rd),
    .ex_memread_i (hz_if.ex_memread),
    .lu_o         (lu)
  );

  assign mw = hz_if.mem_req && !hz_if.mem_ready;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pend_d      = pend_q;
    wait_cnt_d  = wait_cnt_q;
    tmo_d       = tmo_q;
    ctrl        = CTRL_RUN;

    case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (mw) begin
          // flush_cnt_q is left untouched so an interrupted flush resumes on release
          ctrl       = CTRL_FREEZE;
          pend_d     = hz_if.ex_redirect;
          wait_cnt_d = '0;
          state_d    = ST_MEM_WAIT;
        end else if (hz_if.ex_redirect) begin
          ctrl        = CTRL_FLUSH;
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = (FLUSH_RELOAD == '0) ? ST_RUN : ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
          ctrl        = CTRL_FLUSH;
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          state_d     = (flush_cnt_q == FLUSH_CNT_W'(1)) ? ST_RUN : ST_FLUSH;
        end else if (lu) begin
          ctrl = CTRL_STALL;
        end
      end

      ST_MEM_WAIT: begin
        if (hz_if.mem_ready) begin
          wait_cnt_d = '0;
          pend_d     = 1'b0;
          if (pend_q || hz_if.ex_redirect) begin
            ctrl        = CTRL_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = (FLUSH_RELOAD == '0) ? ST_RUN : ST_FLUSH;
          end else if (flush_cnt_q != '0) begin
            ctrl        = CTRL_FLUSH;
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
            state_d     = (flush_cnt_q == FLUSH_CNT_W'(1)) ? ST_RUN : ST_FLUSH;
          end else begin
            // a load-use pair frozen across the wait still needs its bubble
            state_d = ST_RUN;
            if (lu) begin
              ctrl = CTRL_STALL;
            end
          end
        end else begin
          ctrl   = CTRL_FREEZE;
          pend_d = pend_q | hz_if.ex_redirect;
          if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_LIMIT) begin
              tmo_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
      wait_cnt_q  <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
      wait_cnt_q  <= wait_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  // Inputs may show a hazard while reset is held; outputs must still read as idle
  assign ctrl_out = arst_n ? ctrl : CTRL_RUN;

  assign hz_if.pc_en        = ctrl_out.pc_en;
  assign hz_if.if_id_hazard = ctrl_out.if_id_hazard;
  assign hz_if.if_id_flush  = ctrl_out.if_id_flush;
  assign hz_if.id_ex_bubble = ctrl_out.id_ex_bubble;
  assign hz_if.ex_mem_en    = ctrl_out.ex_mem_en;
  assign hz_if.mem_wb_en    = ctrl_out.mem_wb_en;
  assign hz_if.timeout_err  = tmo_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_lu_q;
  logic [CNT_W-1:0] perf_flush_q;
  logic [CNT_W-1:0] perf_mw_q;
  logic             lu_evt;

  // a bubble without a flush is only ever a load-use stall
  assign lu_evt = ctrl.id_ex_bubble && !ctrl.if_id_flush;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_lu_q    <= '0;
      perf_flush_q <= '0;
      perf_mw_q    <= '0;
    end else begin
      if (lu_evt && (perf_lu_q != '1)) begin
        perf_lu_q <= perf_lu_q + CNT_W'(1);
      end
      if (ctrl.if_id_flush && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + CNT_W'(1);
      end
      if (!ctrl.mem_wb_en && (perf_mw_q != '1)) begin
        perf_mw_q <= perf_mw_q + CNT_W'(1);
      end
    end
  end

  assign hz_if.perf_lu_cnt      = perf_lu_q;
  assign hz_if.perf_flush_cnt   = perf_flush_q;
  assign hz_if.perf_memwait_cnt = perf_mw_q;
`endif

endmodule
`default_nettype wire
